// File: rtl/vault_pkg.sv
// Shared types and width helpers for the multi-slot key vault.
// The response struct is sized for the default key width.
package vault_pkg;

  localparam int VAULT_KEY_W = 128;

  typedef enum logic [1:0] {IDLE, WIPE, DONE} state_t;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [VAULT_KEY_W-1:0] data;
  } resp_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keyslot.sv
// One key slot: word storage, written-word mask and sticky lock.
// Write qualification is done by the caller; clear wipes everything.
module keyslot import vault_pkg::*; #(
  parameter int KEY_W = 128,
  parameter int BUS_W = 32,
  localparam int NWORD = KEY_W / BUS_W,
  localparam int WIDX_W = clog2_min1(NWORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr,
  input  logic [WIDX_W-1:0] wr_word,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic              lock,
  output logic [KEY_W-1:0]  key,
  output logic              loaded,
  output logic              locked
);

  logic [BUS_W-1:0] words [NWORD];
  logic [NWORD-1:0] mask;
  logic             lock_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int w = 0; w < NWORD; w++) words[w] <= '0;
      mask   <= '0;
      lock_q <= 1'b0;
    end else begin
      if (wr) begin
        words[wr_word] <= wr_data;
        mask[wr_word]  <= 1'b1;
      end
      // Lock sees the pre-write mask, so a same-cycle final word does not count yet.
      if (lock && (&mask)) lock_q <= 1'b1;
    end
  end

  always_comb begin
    key = '0;
    for (int w = 0; w < NWORD; w++) key[w*BUS_W +: BUS_W] = words[w];
  end

  assign loaded = &mask;
  assign locked = lock_q;

endmodule

// File: rtl/secure_keyslot_vault.sv
// Multi-slot key vault: word-wise loading, sticky locks, key delivery over a
// valid/ready port only, and a hardware zeroize sequencer.
module secure_keyslot_vault import vault_pkg::*; #(
  parameter int KEY_W = VAULT_KEY_W,
  parameter int BUS_W = 32,
  parameter int NSLOT = 4,
  localparam int NWORD = KEY_W / BUS_W,
  localparam int SLOT_W = $clog2(NSLOT),
  localparam int WIDX_W = clog2_min1(NWORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [WIDX_W-1:0] wr_word,
  input  logic [BUS_W-1:0]  wr_data,
  output logic              wr_err,
  input  logic              lock_en,
  input  logic [SLOT_W-1:0] lock_slot,
  input  logic              zeroize_req,
  output logic              zeroize_busy,
  input  logic              key_req_valid,
  input  logic [SLOT_W-1:0] key_req_slot,
  output logic              key_req_ready,
  output logic              key_out_valid,
  input  logic              key_out_ready,
  output logic [KEY_W-1:0]  key_out_data,
  output logic              key_out_err,
  output logic [NSLOT-1:0]  slot_loaded,
  output logic [NSLOT-1:0]  slot_locked
);

  state_t            state, state_n;
  logic [SLOT_W-1:0] cnt, cnt_n;
  resp_t             resp, resp_n;
  logic              wr_err_q;
  logic              idle, zstart, wr_ok, lock_ok, req_hs;
  logic [NSLOT-1:0]  clear;
  logic [KEY_W-1:0]  keys [NSLOT];

  assign idle   = (state == IDLE);
  // Zeroize wins over every same-cycle write, lock and request.
  assign zstart = idle & zeroize_req;
  assign wr_ok  = wr_en & idle & ~zeroize_req & ~slot_locked[wr_slot]
                & ({1'b0, wr_word} < (WIDX_W+1)'(NWORD));
  assign lock_ok       = lock_en & idle & ~zeroize_req;
  assign key_req_ready = idle & ~resp.valid;
  assign req_hs        = key_req_valid & key_req_ready & ~zeroize_req;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    keyslot #(.KEY_W(KEY_W), .BUS_W(BUS_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear[i]),
      .wr      (wr_ok && (wr_slot == SLOT_W'(i))),
      .wr_word (wr_word),
      .wr_data (wr_data),
      .lock    (lock_ok && (lock_slot == SLOT_W'(i))),
      .key     (keys[i]),
      .loaded  (slot_loaded[i]),
      .locked  (slot_locked[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clear   = '0;
    unique case (state)
      IDLE: begin
        if (zeroize_req) begin
          state_n = WIPE;
          cnt_n   = '0;
        end
      end
      WIPE: begin
        clear[cnt] = 1'b1;
        if (cnt == SLOT_W'(NSLOT-1)) state_n = DONE;
        else cnt_n = cnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response is snapshotted at handshake; a locked slot cannot change under it
  // except through zeroize, which drops the response anyway.
  always_comb begin
    resp_n = resp;
    if (zstart || (resp.valid && key_out_ready)) begin
      resp_n = '0;
    end else if (req_hs) begin
      resp_n.valid = 1'b1;
      resp_n.err   = ~slot_locked[key_req_slot];
      resp_n.data  = slot_locked[key_req_slot] ? VAULT_KEY_W'(keys[key_req_slot]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      resp     <= resp_n;
      wr_err_q <= wr_en & ~wr_ok;
    end
  end

  assign wr_err        = wr_err_q;
  assign zeroize_busy  = ~idle;
  assign key_out_valid = resp.valid;
  assign key_out_err   = resp.err;
  assign key_out_data  = (resp.valid && !resp.err) ? resp.data[KEY_W-1:0] : '0;

endmodule

// File: tb/tb_secure_keyslot_vault.sv
// Bench for secure_keyslot_vault: behavioural vault model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_secure_keyslot_vault;

  localparam int KEY_W = 128;
  localparam int BUS_W = 32;
  localparam int NSLOT = 4;
  localparam int NWORD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_slot;
  logic [1:0]       wr_word;
  logic [31:0]      wr_data;
  logic             wr_err;
  logic             lock_en;
  logic [1:0]       lock_slot;
  logic             zeroize_req;
  logic             zeroize_busy;
  logic             key_req_valid;
  logic [1:0]       key_req_slot;
  logic             key_req_ready;
  logic             key_out_valid;
  logic             key_out_ready;
  logic [KEY_W-1:0] key_out_data;
  logic             key_out_err;
  logic [NSLOT-1:0] slot_loaded;
  logic [NSLOT-1:0] slot_locked;

  secure_keyslot_vault dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_word(wr_word), .wr_data(wr_data), .wr_err(wr_err),
    .lock_en(lock_en), .lock_slot(lock_slot),
    .zeroize_req(zeroize_req), .zeroize_busy(zeroize_busy),
    .key_req_valid(key_req_valid), .key_req_slot(key_req_slot), .key_req_ready(key_req_ready),
    .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
    .key_out_data(key_out_data), .key_out_err(key_out_err),
    .slot_loaded(slot_loaded), .slot_locked(slot_locked)
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: keys as flat vectors, per-slot written-word sets, locks,
  // and a wipe position (-1 idle, 0..NSLOT-1 slot being wiped, NSLOT final cycle).
  logic [KEY_W-1:0] m_key  [NSLOT];
  logic [NWORD-1:0] m_mask [NSLOT];
  logic [NSLOT-1:0] m_lock;
  int               m_wpos;
  logic             m_rv, m_re, m_wrerr;
  logic [KEY_W-1:0] m_rd;

  logic m_idle, m_zs, m_wok, m_lok, m_hs;
  assign m_idle = (m_wpos < 0);
  assign m_zs   = m_idle && zeroize_req;
  assign m_wok  = wr_en && m_idle && !zeroize_req && !m_lock[wr_slot] && (int'(wr_word) < NWORD);
  assign m_lok  = lock_en && m_idle && !zeroize_req && (m_mask[lock_slot] == '1);
  assign m_hs   = key_req_valid && m_idle && !m_rv && !zeroize_req;

  function automatic logic [NSLOT-1:0] m_loaded();
    logic [NSLOT-1:0] v;
    for (int s = 0; s < NSLOT; s++) v[s] = (m_mask[s] == '1);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        m_key[s]  <= '0;
        m_mask[s] <= '0;
      end
      m_lock  <= '0;
      m_wpos  <= -1;
      m_rv    <= 1'b0;
      m_re    <= 1'b0;
      m_rd    <= '0;
      m_wrerr <= 1'b0;
    end else begin
      m_wrerr <= wr_en && !m_wok;
      if (m_zs || (m_rv && key_out_ready)) begin
        m_rv <= 1'b0;
        m_re <= 1'b0;
        m_rd <= '0;
      end else if (m_hs) begin
        m_rv <= 1'b1;
        m_re <= !m_lock[key_req_slot];
        m_rd <= m_lock[key_req_slot] ? m_key[key_req_slot] : '0;
      end
      if (m_zs) m_wpos <= 0;
      else if (m_wpos == NSLOT) m_wpos <= -1;
      else if (m_wpos >= 0) begin
        m_key[m_wpos]  <= '0;
        m_mask[m_wpos] <= '0;
        m_lock[m_wpos] <= 1'b0;
        m_wpos         <= m_wpos + 1;
      end
      if (m_wok) begin
        m_key[wr_slot][int'(wr_word)*BUS_W +: BUS_W] <= wr_data;
        m_mask[wr_slot][wr_word] <= 1'b1;
      end
      if (m_lok) m_lock[lock_slot] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("wr_err", wr_err, m_wrerr);
      chk("zeroize_busy", zeroize_busy, m_wpos >= 0);
      chk("key_req_ready", key_req_ready, m_idle && !m_rv);
      chk("key_out_valid", key_out_valid, m_rv);
      chk("key_out_err", key_out_err, m_re);
      chk("key_out_data", key_out_data, (m_rv && !m_re) ? m_rd : '0);
      chk("slot_loaded", slot_loaded, m_loaded());
      chk("slot_locked", slot_locked, m_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int s, input int w, input logic [31:0] d);
    wr_en = 1'b1; wr_slot = 2'(s); wr_word = 2'(w); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lock_slot_t(input int s);
    lock_en = 1'b1; lock_slot = 2'(s);
    tick();
    lock_en = 1'b0;
  endtask

  task automatic request(input int s);
    key_req_valid = 1'b1; key_req_slot = 2'(s);
    tick();
    key_req_valid = 1'b0;
  endtask

  task automatic accept();
    key_out_ready = 1'b1;
    tick();
    key_out_ready = 1'b0;
  endtask

  task automatic load_lock(input int s, input logic [31:0] base);
    for (int w = 0; w < NWORD; w++) write_word(s, w, base + 32'(w));
    lock_slot_t(s);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (zeroize_busy && n < 20) begin
      n++;
      tick();
    end
    if (zeroize_busy) chk("wipe timeout", 1'b1, 1'b0);
  endtask

  int busy_n;

  initial begin
    rst = 1'b1; wr_en = 0; wr_slot = 0; wr_word = 0; wr_data = 0;
    lock_en = 0; lock_slot = 0; zeroize_req = 0;
    key_req_valid = 0; key_req_slot = 0; key_out_ready = 0;
    @(posedge clk);
    tick();
    armed = 1'b1;
    chk("reset loaded", slot_loaded, 4'b0000);
    chk("reset locked", slot_locked, 4'b0000);
    chk("reset valid", key_out_valid, 1'b0);
    chk("reset ready", key_req_ready, 1'b0 | 1'b1);
    rst = 1'b0;
    tick();

    // Load, lock and fetch slot 1
    write_word(1, 0, 32'h11111111);
    write_word(1, 1, 32'h22222222);
    write_word(1, 2, 32'h33333333);
    write_word(1, 3, 32'h44444444);
    chk("t1 loaded", slot_loaded, 4'b0010);
    lock_slot_t(1);
    chk("t1 locked", slot_locked, 4'b0010);
    request(1);
    chk("t1 valid", key_out_valid, 1'b1);
    chk("t1 err", key_out_err, 1'b0);
    chk("t1 data", key_out_data, 128'h44444444_33333333_22222222_11111111);
    accept();
    chk("t1 cleared", key_out_valid, 1'b0);

    // Write to locked slot is rejected
    write_word(1, 2, 32'hDEADBEEF);
    chk("t2 wr_err", wr_err, 1'b1);
    tick();
    chk("t2 wr_err pulse", wr_err, 1'b0);
    request(1);
    chk("t2 data", key_out_data, 128'h44444444_33333333_22222222_11111111);
    accept();

    // Unlocked slot request, held response
    request(0);
    chk("t3 valid", key_out_valid, 1'b1);
    chk("t3 err", key_out_err, 1'b1);
    chk("t3 data", key_out_data, 128'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3 hold valid", key_out_valid, 1'b1);
      chk("t3 hold err", key_out_err, 1'b1);
      chk("t3 hold ready", key_req_ready, 1'b0);
    end
    accept();
    chk("t3 cleared", key_out_valid, 1'b0);

    // Zeroize after loading every slot
    for (int s = 0; s < NSLOT; s++) load_lock(s, 32'hA0000000 + 32'(s << 8));
    chk("t4 all locked", slot_locked, 4'b1111);
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    busy_n = 0;
    while (zeroize_busy && busy_n < 20) begin
      busy_n++;
      tick();
    end
    chk("t4 busy cycles", 128'(busy_n), 128'd5);
    chk("t4 locked", slot_locked, 4'b0000);
    chk("t4 loaded", slot_loaded, 4'b0000);
    request(2);
    chk("t4 err", key_out_err, 1'b1);
    accept();

    // Zeroize drops a pending response; writes during wipe are rejected
    load_lock(0, 32'h5A5A0000);
    request(0);
    chk("t5 valid", key_out_valid, 1'b1);
    chk("t5 data", key_out_data, 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000);
    zeroize_req = 1'b1;
    tick();
    zeroize_req = 1'b0;
    chk("t5 dropped", key_out_valid, 1'b0);
    chk("t5 data zero", key_out_data, 128'h0);
    write_word(2, 0, 32'h12345678);
    chk("t5 wr_err", wr_err, 1'b1);
    wait_idle();

    // Lock only after the slot is fully loaded
    write_word(3, 1, 32'hBBBB0001);
    lock_slot_t(3);
    chk("t6 no lock partial", slot_locked[3], 1'b0);
    write_word(3, 0, 32'hBBBB0000);
    write_word(3, 2, 32'hBBBB0002);
    wr_en = 1'b1; wr_slot = 2'd3; wr_word = 2'd3; wr_data = 32'hBBBB0003;
    lock_en = 1'b1; lock_slot = 2'd3;
    tick();
    wr_en = 1'b0; lock_en = 1'b0;
    chk("t6 same-cycle no lock", slot_locked[3], 1'b0);
    chk("t6 loaded", slot_loaded[3], 1'b1);
    lock_slot_t(3);
    chk("t6 locked", slot_locked[3], 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 399) == 0);
      wr_en         = ($urandom_range(0, 2) == 0);
      wr_slot       = 2'($urandom_range(0, 3));
      wr_word       = 2'($urandom_range(0, 3));
      wr_data       = $urandom;
      lock_en       = ($urandom_range(0, 5) == 0);
      lock_slot     = 2'($urandom_range(0, 3));
      zeroize_req   = ($urandom_range(0, 49) == 0);
      key_req_valid = ($urandom_range(0, 2) == 0);
      key_req_slot  = 2'($urandom_range(0, 3));
      key_out_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    rst = 1'b0; wr_en = 0; lock_en = 0; zeroize_req = 0; key_req_valid = 0; key_out_ready = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
